// File: rtl/column_pkg.sv
// column_pkg: encoder state type, default sizes and value-to-spike-time mapping
// Build option: SPIKE_ENC_INVERT_EN makes higher intensities spike earlier.
package column_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} enc_state_e;
  localparam int GAMMA_LEN_DEF = 16;
  localparam int VAL_W_DEF = $clog2(GAMMA_LEN_DEF) + 1;
  localparam logic [VAL_W_DEF-1:0] NO_SPIKE = '1;
`ifdef SPIKE_ENC_INVERT_EN
  localparam bit INVERT = 1'b1;
`else
  localparam bit INVERT = 1'b0;
`endif
  // No-spike codes (v >= glen) pass through unchanged in both modes
  function automatic int eff_time(input int v, input int glen);
    return (INVERT && v < glen) ? glen - 1 - v : v;
  endfunction
endpackage

// File: rtl/spike_enc_channel.sv
// spike_enc_channel: one channel's committed spike time and its window comparator
// Ports: clk/rst; t_i next window time; run_i next state is RUN; load_i commit val_i; spike_o registered spike.
module spike_enc_channel import column_pkg::*; #(
  parameter int GAMMA_LEN = GAMMA_LEN_DEF,
  parameter int VAL_W = $clog2(GAMMA_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] t_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [VAL_W-1:0] val_i,
  output logic             spike_o
);
  logic [VAL_W-1:0] active_q, active_d;
  logic spike_q;
  always_comb active_d = load_i ? VAL_W'(eff_time(int'(val_i), GAMMA_LEN)) : active_q;
  // Compare against next-cycle time so the registered spike lands in the cycle where t equals the value
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '1;
      spike_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      spike_q  <= run_i && t_i == active_d && active_d < VAL_W'(GAMMA_LEN);
    end
  end
  assign spike_o = spike_q;
endmodule

// File: rtl/spike_time_encoder.sv
// spike_time_encoder: per-channel intensity to single-spike-per-gamma-window temporal code
// Ports: clk, rst (sync, active-high); grst gamma signal (rising edge = boundary);
//   in_valid/in_ready/in_data frame input into the shadow register;
//   spike_out per-channel spikes; gamma_start window t=0 pulse; window_trunc early-boundary pulse.
// Build option: SPIKE_ENC_INVERT_EN (see column_pkg).
module spike_time_encoder import column_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int GAMMA_LEN = GAMMA_LEN_DEF,
  parameter int VAL_W = $clog2(GAMMA_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    grst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*VAL_W-1:0] in_data,
  output logic [NUM_CH-1:0]       spike_out,
  output logic                    gamma_start,
  output logic                    window_trunc
);
  localparam logic [VAL_W-1:0] LAST = VAL_W'(GAMMA_LEN - 1);
  enc_state_e state_q, state_d;
  logic [VAL_W-1:0] t_q, t_d;
  logic [NUM_CH*VAL_W-1:0] shadow_q, shadow_d;
  logic grst_q, bnd, acc, shadow_vld_q, shadow_vld_d;
  logic gs_q, gs_d, wt_q, wt_d, run_d;
  assign bnd = grst & ~grst_q;
  assign in_ready = ~shadow_vld_q & ~rst;
  assign acc = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end
  always_comb begin
    state_d = bnd ? RUN : (state_q == RUN && t_q == LAST) ? DONE : state_q;
    t_d = bnd ? '0 : (state_q == RUN && t_q != LAST) ? t_q + VAL_W'(1) : t_q;
  end
  always_comb begin
    run_d = state_d == RUN;
    gs_d  = bnd;
    wt_d  = bnd && state_q == RUN && t_q != LAST;
  end
  // A same-cycle accept sets the shadow after the boundary has consumed its old contents
  always_comb begin
    shadow_vld_d = acc | (shadow_vld_q & ~bnd);
    shadow_d = acc ? in_data : shadow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grst_q       <= 1'b0;
      shadow_vld_q <= 1'b0;
      shadow_q     <= '0;
      gs_q         <= 1'b0;
      wt_q         <= 1'b0;
    end else begin
      grst_q       <= grst;
      shadow_vld_q <= shadow_vld_d;
      shadow_q     <= shadow_d;
      gs_q         <= gs_d;
      wt_q         <= wt_d;
    end
  end
  assign gamma_start = gs_q;
  assign window_trunc = wt_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_enc_channel #(.GAMMA_LEN(GAMMA_LEN), .VAL_W(VAL_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .t_i    (t_d),
      .run_i  (run_d),
      .load_i (bnd),
      .val_i  (shadow_vld_q ? shadow_q[i*VAL_W +: VAL_W] : '1),
      .spike_o(spike_out[i])
    );
  end
endmodule

// File: doc/spike_time_encoder.md
# spike_time_encoder

Temporal spike encoder: converts per-channel multi-bit intensity values into single-spike-per-gamma-cycle temporal codes (spike time = value) and drives the 1-bit-per-channel spike inputs of the muxed replay buffer directly upstream of it. Values are loaded through a valid/ready port into a shadow register and committed at each gamma boundary, so a new input frame can be staged while the current one is being emitted. Gamma boundaries come from the same `grst` signal the column uses, sampled here as data on `clk`.

## Interface
- `NUM_CH`, 2: spike channels; one output bit per channel.
- `GAMMA_LEN`, 16: clock cycles per gamma window; equals the replay buffer depth.
- `VAL_W`, `$clog2(GAMMA_LEN)+1`: width of one channel value; values ≥ `GAMMA_LEN` mean "no spike".

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `grst` in 1: gamma signal, sampled on `clk`; each 0→1 transition marks a boundary.
- `in_valid` in 1: `in_data` holds a frame.
- `in_ready` out 1: shadow register empty; 0 while `rst` is high.
- `in_data` in `NUM_CH*VAL_W`: channel i occupies bits `[i*VAL_W +: VAL_W]`.
- `spike_out` out `NUM_CH`: one-cycle spike per channel per window.
- `gamma_start` out 1: one-cycle pulse in window cycle t=0.
- `window_trunc` out 1: one-cycle pulse when a boundary cuts a window short.

## Operation
- Boundary detect: `grst_q` holds the previous sample and resets to 0. The boundary is `grst & ~grst_q`. If `grst` is high in the first cycle after reset, that cycle counts as a boundary.
- Shadow: accept occurs when `in_valid & in_ready`. The frame is written to `shadow` and `shadow_vld` is set. `in_ready = ~shadow_vld & ~rst`.
- States: IDLE, RUN, DONE. Reset enters IDLE.
  - IDLE: no spikes. A boundary moves to RUN.
  - RUN: counter `t` counts 0..`GAMMA_LEN-1`. At `t == GAMMA_LEN-1` with no boundary, the block moves to DONE.
  - DONE: outputs stay 0 until the next boundary, which moves to RUN.
- At a boundary, in any state:
  - `t <= 0`.
  - If `shadow_vld`, `active <= shadow` and `shadow_vld` is cleared. Otherwise `active` is loaded with all-no-spike, giving a silent window.
- Boundary and accept in the same cycle:
  - The window takes the old shadow contents, or goes silent if the shadow was empty.
  - The new frame lands in the shadow. Its `shadow_vld` set wins over the clear.
- Emit: in RUN, channel i spikes when `t == active[i]` and `active[i] < GAMMA_LEN`. At most one spike per channel per window.
- Early boundary: a boundary arriving while in RUN with `t < GAMMA_LEN-1`:
  - pulses `window_trunc`;
  - drops spikes not yet emitted;
  - starts a new window.
- Mid-operation `rst`: clears the state to IDLE, `t`, `active`, `shadow_vld` and `grst_q`. A pending frame is lost.

## Timing
- Reset values: `spike_out`=0, `gamma_start`=0, `window_trunc`=0, `in_ready`=0 during reset and 1 in the first cycle after.
- All outputs except `in_ready` are registered.
- Boundary sampled at edge E0: `gamma_start` is high in the cycle after E0. The spike for value v is high in cycle E0+1+v, i.e. in the cycle where t = v.
- `window_trunc` is high in the same cycle as the new window's `gamma_start`.
- Shadow-to-active latency: one boundary. A frame accepted during window k is emitted in window k+1.
- `in_ready` drops the cycle after an accept and rises the cycle after the boundary that consumes the frame.

## Configuration
- `SPIKE_ENC_INVERT_EN` defined: effective time is `GAMMA_LEN-1-v` for v < `GAMMA_LEN`, so higher intensity spikes earlier. No-spike codes are unchanged. Inversion is applied when the value is committed to `active`.
- `SPIKE_ENC_INVERT_EN` undefined: effective time is v.

## Structure
- Shared package `column_pkg` holds:
  - `enc_state_e` (IDLE/RUN/DONE);
  - default constants `GAMMA_LEN_DEF` = 16 and `NO_SPIKE` (all-ones `VAL_W`);
  - function `eff_time(v)`, which contains the invert logic.
- Sub-module `spike_enc_channel`: holds one channel's `active` value and comparator. Inputs are `t`, run enable and load; output is its spike bit. It is instantiated `NUM_CH` times in a generate loop.

## Test plan
- Reset, accept frame {ch0=3, ch1=0}, `grst` rises at E0 → `gamma_start` at E0+1; ch1 spike at E0+1; ch0 spike at E0+4; nothing else for 16 cycles; state DONE.
- Frame {16, 31} (no-spike codes) → `gamma_start` only, `spike_out` stays 0.
- Boundary with empty shadow → silent window. Accept in the same cycle as a boundary → that frame spikes in the following window, not the current one.
- Frame {10, 12}, next boundary 8 cycles after E0 → `window_trunc`=1 at that `gamma_start`; no spikes at t=10 or t=12 of the old window.
- `rst` asserted at t=2 with ch0=5 → no spike at t=5; all outputs 0; `in_ready`=1 after reset; the first boundary after reset starts a silent window.
- With `SPIKE_ENC_INVERT_EN` defined, frame {0, 15} → ch0 spikes at t=15, ch1 at t=0.
